// File: rtl/pwm_serial_driver.sv
// Multi-channel PWM engine: each phase step it computes one bit per channel and
// shifts the bits MSB-channel-first into an external SIPO latch via sdata/sclk/slatch.
module pwm_serial_driver #(
    parameter int CH     = 8,
    parameter int DW     = 8,
    parameter int PERIOD = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [$clog2(CH)-1:0] wr_ch,
    input  logic [DW-1:0]         wr_duty,
    output logic                  sdata,
    output logic                  sclk,
    output logic                  slatch,
    output logic                  frame_done,
    output logic [1:0]            fsm_state
);

    localparam int             CW         = $clog2(CH);
    localparam logic [CW-1:0]  BIT_LAST   = CW'(CH - 1);
    localparam logic [DW-1:0]  PHASE_LAST = DW'(PERIOD - 1);

    typedef enum logic [1:0] {LOAD, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    state_t          state;
    logic [DW-1:0]   pending [CH];
    logic [DW-1:0]   shadow  [CH];
    logic [DW-1:0]   phase;
    logic [CW-1:0]   bit_cnt;
    logic [CH-1:0]   shreg;
    logic [CH-1:0]   load_bits;

    assign fsm_state = state;

    // Write handshake: a write is taken on any rising edge where wr_valid and
    // wr_ready are both 1; wr_ready stays 1 whenever reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ready <= 1'b0;
            for (int k = 0; k < CH; k++) pending[k] <= '0;
        end else begin
            wr_ready <= 1'b1;
            if (wr_valid && wr_ready && (32'(wr_ch) < CH))
                pending[wr_ch] <= wr_duty;
        end
    end

    // At phase 0 the new period's duties come straight from pending, because
    // shadow is only being loaded on this same edge.
    always_comb begin
        load_bits = '0;
        for (int k = 0; k < CH; k++)
            load_bits[k] = (phase == '0) ? (phase < pending[k]) : (phase < shadow[k]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= LOAD;
            phase      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            sdata      <= 1'b0;
            sclk       <= 1'b0;
            slatch     <= 1'b0;
            frame_done <= 1'b0;
            for (int k = 0; k < CH; k++) shadow[k] <= '0;
        end else begin
            slatch     <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                LOAD: begin
                    if (phase == '0)
                        for (int k = 0; k < CH; k++) shadow[k] <= pending[k];
                    shreg   <= load_bits;
                    bit_cnt <= '0;
                    sclk    <= 1'b0;
                    state   <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    sdata <= shreg[CH-1];
                    sclk  <= 1'b0;
                    state <= SHIFT_HI;
                end
                SHIFT_HI: begin
                    sclk  <= 1'b1;
                    shreg <= {shreg[CH-2:0], 1'b0};
                    if (bit_cnt == BIT_LAST) begin
                        state <= LATCH;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= SHIFT_LO;
                    end
                end
                LATCH: begin
                    slatch     <= 1'b1;
                    sclk       <= 1'b0;
                    frame_done <= (phase == PHASE_LAST);
                    phase      <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
                    state      <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_serial_driver.sv
// Bench for pwm_serial_driver: cycle-position model of the serial protocol plus an
// emulated downstream latch register, directed scenarios and random duty writes.
module tb_pwm_serial_driver;

    localparam int CH     = 8;
    localparam int DW     = 8;
    localparam int PERIOD = 100;
    localparam int SLOT   = 2 * CH + 2;
    localparam int PLEN   = PERIOD * SLOT;
    localparam int NPER   = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_valid = 1'b0;
    logic [2:0]    wr_ch = '0;
    logic [DW-1:0] wr_duty = '0;
    logic          wr_ready, sdata, sclk, slatch, frame_done;
    logic [1:0]    fsm_state;

    pwm_serial_driver #(.CH(CH), .DW(DW), .PERIOD(PERIOD)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_ch(wr_ch), .wr_duty(wr_duty), .sdata(sdata), .sclk(sclk),
        .slatch(slatch), .frame_done(frame_done), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int c        = -1;
    int pend [CH];
    int eff  [CH];
    int hi_cnt [NPER][CH];
    logic [CH-1:0] cap, lat, exp_vec, first_latch_val, p2_s0_val;
    logic prev_sclk;
    int first_latch_c = -1;
    int first_fd_c    = -1;
    logic m_wv;
    int m_wch, m_wd, pos, slot, ph, per, t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, c);
        end
    endtask

    task automatic wait_to(input int target);
        int guard;
        guard = 0;
        while (c < target && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (c < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got cycle %0d, expected cycle %0d", c, target);
        end
    endtask

    task automatic write_at(input int te, input int ch, input int duty);
        wait_to(te - 1);
        wr_valid = 1'b1;
        wr_ch    = 3'(ch);
        wr_duty  = 8'(duty);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Model: position inside slot/period is plain arithmetic on the cycle index.
    initial begin : monitor
        forever begin
            @(posedge clk);
            if (!reset) begin
                c = -1;
                for (int k = 0; k < CH; k++) begin pend[k] = 0; eff[k] = 0; end
                cap = '0; lat = '0; prev_sclk = 1'b0;
                first_latch_c = -1; first_fd_c = -1; first_latch_val = '0;
                #1;
                check("rst_sdata", sdata, 0);
                check("rst_sclk", sclk, 0);
                check("rst_slatch", slatch, 0);
                check("rst_frame_done", frame_done, 0);
                check("rst_wr_ready", wr_ready, 0);
            end else begin
                m_wv = wr_valid; m_wch = wr_ch; m_wd = wr_duty;
                c++;
                pos = c % SLOT; slot = c / SLOT; ph = slot % PERIOD; per = slot / PERIOD;
                if (pos == 0 && ph == 0) eff = pend;
                if (m_wv && c >= 1 && m_wch < CH) pend[m_wch] = m_wd;
                for (int k = 0; k < CH; k++) exp_vec[k] = (ph < eff[k]);
                #1;
                check("wr_ready", wr_ready, 1);
                check("sclk", sclk, int'(pos >= 2 && pos <= 2 * CH && pos % 2 == 0));
                check("slatch", slatch, int'(pos == SLOT - 1));
                check("frame_done", frame_done, int'(pos == SLOT - 1 && ph == PERIOD - 1));
                if (pos >= 1 && pos <= 2 * CH)
                    check("sdata", sdata, exp_vec[CH - 1 - (pos - 1) / 2]);
                if (sclk && !prev_sclk) cap = {cap[CH-2:0], sdata};
                prev_sclk = sclk;
                if (slatch) begin
                    lat = cap;
                    check("latched", lat, exp_vec);
                    if (per < NPER)
                        for (int k = 0; k < CH; k++) hi_cnt[per][k] += lat[k];
                    if (first_latch_c < 0) begin first_latch_c = c; first_latch_val = lat; end
                    if (per == 2 && ph == 0) p2_s0_val = lat;
                end
                if (frame_done && first_fd_c < 0) first_fd_c = c;
            end
        end
    end

    initial begin : main
        for (int p = 0; p < NPER; p++)
            for (int k = 0; k < CH; k++) hi_cnt[p][k] = 0;
        p2_s0_val = '0;
        repeat (4) @(negedge clk);
        reset = 1'b1;

        // Basic duty written during the first period.
        write_at(100, 0, 10);
        write_at(200, 7, 80);
        wait_to(PLEN);
        check("first_latch_cycle", first_latch_c, 17);
        check("first_latch_bits", first_latch_val, 0);
        check("first_frame_done", first_fd_c, 1799);

        // Bit order: ch1..ch7 full on, ch0 off.
        for (int k = 0; k < CH; k++) write_at(PLEN + 50 + k, k, (k == 0) ? 0 : 100);
        wait_to(2 * PLEN);
        check("p0_ch0_hi", hi_cnt[0][0], 0);
        check("p0_ch7_hi", hi_cnt[0][7], 0);
        check("p1_ch0_hi", hi_cnt[1][0], 10);
        check("p1_ch7_hi", hi_cnt[1][7], 80);
        check("p1_ch3_hi", hi_cnt[1][3], 0);

        // Saturation and mid-period setup.
        for (int k = 0; k < CH; k++)
            write_at(2 * PLEN + 40 + k, k, (k == 2) ? 200 : (k == 3) ? 40 : 0);
        wait_to(3 * PLEN);
        check("p2_slot0_bits", p2_s0_val, 8'hFE);
        check("p2_ch1_hi", hi_cnt[2][1], 100);
        check("p2_ch0_hi", hi_cnt[2][0], 0);

        write_at(3 * PLEN + 20 * SLOT + 5, 3, 60);
        wait_to(4 * PLEN);
        check("p3_ch3_hi", hi_cnt[3][3], 40);
        check("p3_ch2_sat", hi_cnt[3][2], 100);
        check("p3_ch5_off", hi_cnt[3][5], 0);

        // Write on the very commit edge lands one period later.
        write_at(5 * PLEN, 0, 33);
        check("p4_ch3_hi", hi_cnt[4][3], 60);
        wait_to(6 * PLEN);
        check("p5_ch0_hi", hi_cnt[5][0], 0);

        t = c;
        repeat (40) begin
            t += $urandom_range(20, 300);
            write_at(t, $urandom_range(0, CH - 1), $urandom_range(0, 255));
        end
        wait_to(((c / PLEN) + 2) * PLEN);
        check("p6_ch0_hi", hi_cnt[6][0], 33);

        // Reset right after the 4th sclk rise of a slot.
        wait_to((c / SLOT + 1) * SLOT + 8);
        check("pre_rst_sclk", sclk, 1);
        reset = 1'b0;
        #1;
        check("async_sclk", sclk, 0);
        check("async_sdata", sdata, 0);
        check("async_slatch", slatch, 0);
        check("async_frame_done", frame_done, 0);
        check("async_wr_ready", wr_ready, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_to(PLEN);
        check("re_first_latch_cycle", first_latch_c, 17);
        check("re_first_latch_bits", first_latch_val, 0);
        check("re_first_frame_done", first_fd_c, 1799);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
